// File: rtl/mul_debug.sv
// Two-stage RV32M multiply unit (MUL/MULH/MULHSU/MULHU), fixed 2-edge latency, no back-pressure.
// Optional macro MUL_DEBUG_TRACE_EN adds a completion trace print and an io_op X/Z check.
module mul_debug (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_v,
  input  logic [31:0] io_a,
  input  logic [31:0] io_b,
  input  logic [1:0]  io_op,
  output logic [31:0] io_res
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  logic        v_q, v_d;
  logic [1:0]  op_q, op_d;
  logic [32:0] a_q, a_d;
  logic [32:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [63:0] a_wide, b_wide, prod;

  // Operand data only loads on a valid issue so idle-cycle inputs (even X) never reach stage 2.
  always_comb begin
    v_d  = io_v;
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    if (io_v) begin
      op_d = io_op;
      a_d  = (io_op == OP_MULHU) ? {1'b0, io_a} : {io_a[31], io_a};
      b_d  = io_op[1] ? {1'b0, io_b} : {io_b[31], io_b};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q  <= 1'b0;
      op_q <= OP_MUL;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v_q  <= v_d;
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Low 64 bits of the 33x33 signed product: sign-extend to 64 and multiply modulo 2^64.
  assign a_wide = {{31{a_q[32]}}, a_q};
  assign b_wide = {{31{b_q[32]}}, b_q};
  assign prod   = a_wide * b_wide;

  always_comb begin
    res_d = res_q;
    if (v_q) begin
      res_d = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign io_res = res_q;

`ifdef MUL_DEBUG_TRACE_EN
  always @(posedge clock) begin
    if (!reset && v_q) begin
      $display("mul_debug: op=%0d a=%08h b=%08h res=%08h", op_q, a_q[31:0], b_q[31:0], res_d);
    end
  end

  always @(posedge clock) begin
    if (!reset && io_v) begin
      assert (!$isunknown(io_op))
        else $error("mul_debug: io_op has X/Z bits while io_v=1 (%b)", io_op);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mul_debug.sv
// Self-checking bench for mul_debug: vector table plus a queue scoreboard that checks io_res every cycle.
module tb_mul_debug;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_v  = 1'b0;
  logic [31:0] io_a  = '0;
  logic [31:0] io_b  = '0;
  logic [1:0]  io_op = '0;
  logic [31:0] io_res;

  mul_debug dut (
    .clock (clock),
    .reset (reset),
    .io_v  (io_v),
    .io_a  (io_a),
    .io_b  (io_b),
    .io_op (io_op),
    .io_res(io_res)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] exp_q[$];
  logic        s1_v     = 1'b0;
  logic [31:0] last_res = '0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: io_res=%08h expected=%08h", name, got, want);
    end
  endtask

  // One clock: drive inputs, step the bench's pipeline model at the edge, check io_res at the falling edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic rst, input logic [31:0] exp);
    logic fire;
    reset = rst;
    io_v  = v;
    io_a  = a;
    io_b  = b;
    io_op = op;
    if (v && !rst) exp_q.push_back(exp);
    @(posedge clock);
    fire = s1_v;
    s1_v = v && !rst;
    if (rst) begin
      exp_q.delete();
      fire     = 1'b0;
      last_res = '0;
    end
    @(negedge clock);
    if (fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: io_res=%08h expected=none", io_res);
      end else begin
        last_res = exp_q.pop_front();
        check("result", io_res, last_res);
      end
    end else begin
      check("hold", io_res, last_res);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, '0);
  endtask

  initial begin
    vecs[0]  = '{32'h00000007, 32'h00000006, 2'd0, 32'h0000002A};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'h00000001};
    vecs[2]  = '{32'h80000000, 32'h80000000, 2'd1, 32'h40000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000002, 2'd1, 32'hFFFFFFFF};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'hFFFFFFFF};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 32'hFFFFFFFE};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 2'd0, 32'h80000000};
    vecs[7]  = '{32'h12345678, 32'h00000010, 2'd1, 32'h00000001};
    vecs[8]  = '{32'h00000002, 32'h80000000, 2'd2, 32'h00000001};
    vecs[9]  = '{32'h00000002, 32'h80000000, 2'd1, 32'hFFFFFFFF};
    vecs[10] = '{32'h80000000, 32'h00000002, 2'd2, 32'hFFFFFFFF};
    vecs[11] = '{32'h80000000, 32'h00000002, 2'd3, 32'h00000001};
    vecs[12] = '{32'h0000FFFF, 32'h0000FFFF, 2'd0, 32'hFFFE0001};
    vecs[13] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 2'd1, 32'h3FFFFFFF};

    // Reset for two cycles, then idle with io_v low.
    cycle(1'b0, '0, '0, 2'd0, 1'b1, '0);
    cycle(1'b0, '0, '0, 2'd0, 1'b1, '0);
    idle(5);

    // Whole table back-to-back, one issue per cycle.
    for (int i = 0; i < 14; i++) cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].exp);
    idle(2);

    // Same table with a bubble after each issue.
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].exp);
      idle(1);
    end
    idle(1);

    // Bubble hold: MULHU giving 1, then random idle operands must not disturb it.
    cycle(1'b1, 32'h00010000, 32'h00010000, 2'd3, 1'b0, 32'h00000001);
    idle(4);
    check("bubble_hold", io_res, 32'h00000001);

    // Reset mid-operation: MUL 3*5 in stage 1 is discarded by reset on the next edge.
    cycle(1'b1, 32'd3, 32'd5, 2'd0, 1'b0, 32'd15);
    cycle(1'b0, '0, '0, 2'd0, 1'b1, '0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (io_res === 32'd15) begin
        failures++;
        $display("FAIL reset_drop: io_res=%08h required=not 0000000f", io_res);
      end
    end

    // An op presented in the same cycle as reset is dropped.
    cycle(1'b1, 32'd9, 32'd9, 2'd0, 1'b0, 32'd81);
    cycle(1'b1, 32'd4, 32'd4, 2'd0, 1'b1, 32'd16);
    idle(3);
    check("reset_same_cycle", io_res, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
